// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the line-granular data memory and the data cache
// address split: line width, byte-offset width and the responder FSM
// state encoding.
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int LINE_W   = 256;  // 32-byte line
    localparam int OFFSET_W = 5;    // byte offset within a line

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } dmem_state_t;

endpackage : dmem_pkg

// File: rtl/dmem_line_array.sv
// ---------------------------------------------------------------------------
// dmem_line_array
// DEPTH x LINE_W line storage with a synchronous write port and a registered
// read port sharing one index.
//
// Ports:
//   i_clk      clock
//   i_rst_n    async active-low reset (clears the read register only)
//   i_we       write i_wdata into line i_idx on the rising edge
//   i_re       load the read register on the rising edge
//   i_rd_zero  with i_re, load zero instead of the stored line
//   i_idx      line index
//   i_wdata    write line data
//   o_rdata    registered read data; holds until the next i_re
// ---------------------------------------------------------------------------
module dmem_line_array #(
    parameter int LINE_W = 256,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_rd_zero,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    // Storage is deliberately not reset.
    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rd_zero ? '0 : r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_line_array

// File: rtl/dmem_line_responder.sv
// ---------------------------------------------------------------------------
// dmem_line_responder
// Responder end of the cache-to-memory interface. Accepts one line request
// at a time, waits LATENCY edges with a down-counter, then performs the
// read or write and pulses ack_o for one cycle.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-low reset
//   addr_i    byte address of the line (bits [4:0] ignored)
//   data_i    write line data
//   enable_i  request valid, held by the initiator until ack
//   write_i   1 = write line, 0 = read line
//   data_o    read line data, valid in the ack cycle and held afterwards
//   ack_o     one-cycle completion pulse
//
// Build option: define DMEM_BOUNDS_CHECK_EN to flag requests with nonzero
// address bits above the index field; those writes are dropped and those
// reads return zero. Without it the upper bits are ignored (aliasing).
// ---------------------------------------------------------------------------
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = dmem_pkg::LINE_W,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TOP_LSB = OFFSET_W + IDX_W;

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_dec;
    logic              w_load;
    logic              w_enter_ack;

    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;

    logic [IDX_W-1:0]  w_addr_idx;
    logic [IDX_W-1:0]  w_op_idx;
    logic              w_op_write;
    logic [LINE_W-1:0] w_op_wdata;
    logic              w_op_oor;
    logic              w_we;
    logic              w_re;
    logic              w_unused;

    assign w_addr_idx = addr_i[OFFSET_W +: IDX_W];
    assign w_cnt_dec  = r_cnt - 8'd1;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // BUSY exits on the edge where the counter reaches zero, so the ack
    // cycle lands LATENCY cycles after the acceptance cycle.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_enter_ack = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_load = 1'b1;
                    if (LATENCY == 1) begin
                        w_next      = ST_ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (w_cnt_dec == 8'd0) begin
                    w_next      = ST_ACK;
                    w_enter_ack = 1'b1;
                end
            end
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign ack_o = (r_state == ST_ACK);

    // ---------------- Counter and capture ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= 8'd0;
        end else if (w_load) begin
            r_cnt <= 8'(LATENCY - 1);
        end else if (r_state == ST_BUSY) begin
            r_cnt <= w_cnt_dec;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_load) begin
            r_idx   <= w_addr_idx;
            r_write <= write_i;
            r_wdata <= data_i;
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    logic r_oor;
    logic w_addr_oor;

    assign w_addr_oor = |addr_i[ADDR_W-1:TOP_LSB];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_oor <= 1'b0;
        end else if (w_load) begin
            r_oor <= w_addr_oor;
`ifndef SYNTHESIS
            if (w_addr_oor) begin
                $display("dmem_line_responder: out-of-range access addr=%h", addr_i);
            end
`endif
        end
    end

    assign w_unused = ^addr_i[OFFSET_W-1:0];
`else
    assign w_unused = ^{addr_i[ADDR_W-1:TOP_LSB], addr_i[OFFSET_W-1:0]};
`endif

    // With LATENCY==1 the operation happens on the acceptance edge itself,
    // before the capture registers are loaded, so use the live inputs then.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_op_idx   = w_addr_idx;
            w_op_write = write_i;
            w_op_wdata = data_i;
`ifdef DMEM_BOUNDS_CHECK_EN
            w_op_oor   = w_addr_oor;
`else
            w_op_oor   = 1'b0;
`endif
        end else begin
            w_op_idx   = r_idx;
            w_op_write = r_write;
            w_op_wdata = r_wdata;
`ifdef DMEM_BOUNDS_CHECK_EN
            w_op_oor   = r_oor;
`else
            w_op_oor   = 1'b0;
`endif
        end
    end

    assign w_we = w_enter_ack &  w_op_write & ~w_op_oor;
    assign w_re = w_enter_ack & ~w_op_write;

    dmem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_we      (w_we),
        .i_re      (w_re),
        .i_rd_zero (w_op_oor),
        .i_idx     (w_op_idx),
        .i_wdata   (w_op_wdata),
        .o_rdata   (data_o)
    );

endmodule : dmem_line_responder

// File: tb/tb_dmem_line_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_line_responder
// Directed self-checking bench for dmem_line_responder (LATENCY=10,
// DEPTH=512). Inputs are driven 1 time unit after the rising edge and
// outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_dmem_line_responder;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int DEPTH   = 512;
    localparam int LATENCY = 10;
    localparam int LIMIT   = 200;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              en;
    logic              wr;
    logic [LINE_W-1:0] rdata;
    logic              ack;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_line_responder #(
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .addr_i   (addr),
        .data_i   (wdata),
        .enable_i (en),
        .write_i  (wr),
        .data_o   (rdata),
        .ack_o    (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] pat(input logic [7:0] s);
        logic [LINE_W-1:0] p;
        for (int i = 0; i < 32; i++) p[i*8 +: 8] = s + 8'(i);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and hold enable until ack; returns in the
    // ack cycle with lat = cycles from acceptance to ack.
    task automatic req(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                       input logic w, output int lat);
        addr = a; wdata = d; wr = w; en = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (ack !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        en = 1'b0;
    endtask

    // Request plus latency check and single-pulse check.
    task automatic op(input string tag, input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] d, input logic w,
                      output logic [LINE_W-1:0] rd);
        int lat;
        req(a, d, w, lat);
        chk({tag, "_lat"}, LINE_W'(lat), LINE_W'(LATENCY));
        rd = rdata;
        @(posedge clk); #1;
        chk({tag, "_ackpulse"}, LINE_W'(ack), '0);
    endtask

    initial begin
        logic [LINE_W-1:0] rd;
        int lat;
        int n;

        rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", LINE_W'(ack), '0);
        chk("rst_data", rdata, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload line 2, then reset again: contents survive reset.
        op("pre2", 32'h0000_0040, pat(8'h20), 1'b1, rd);
        rst_n = 1'b0;
        #2;
        chk("rst2_ack", LINE_W'(ack), '0);
        chk("rst2_data", rdata, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset then read line 2.
        op("rd2", 32'h0000_0040, '0, 1'b0, rd);
        chk("rd2_data", rd, pat(8'h20));

        // Write then read index 32; write leaves data_o alone.
        op("wrA5", 32'h0000_0400, {32{8'hA5}}, 1'b1, rd);
        chk("wrA5_data_o_held", rd, pat(8'h20));
        op("rdA5", 32'h0000_0400, '0, 1'b0, rd);
        chk("rdA5_data", rd, {32{8'hA5}});

        // Writeback then refill with enable held high.
        op("pre256", 32'h0000_2000, pat(8'h30), 1'b1, rd);
        addr = 32'h0000_1000; wdata = pat(8'h40); wr = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (ack !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("wb_lat", LINE_W'(lat), LINE_W'(LATENCY));
        wr = 1'b0; addr = 32'h0000_2000;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack !== 1'b1 && n < LIMIT);
        en = 1'b0;
        chk("refill_gap", LINE_W'(n), LINE_W'(LATENCY + 1));
        chk("refill_data", rdata, pat(8'h30));
        @(posedge clk); #1;
        chk("refill_ackpulse", LINE_W'(ack), '0);
        op("rdwb", 32'h0000_1000, '0, 1'b0, rd);
        chk("rdwb_data", rd, pat(8'h40));

        // Mid-request input changes are ignored.
        op("pre5", 32'h0000_00A0, pat(8'h50), 1'b1, rd);
        op("pre6", 32'h0000_00C0, pat(8'h60), 1'b1, rd);
        addr = 32'h0000_00A0; wr = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        addr = 32'h0000_00C0; en = 1'b0; wr = 1'b1; wdata = pat(8'h99);
        lat = 1;
        while (ack !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("mid_lat", LINE_W'(lat), LINE_W'(LATENCY));
        chk("mid_data", rdata, pat(8'h50));
        @(posedge clk); #1;
        chk("mid_ackpulse", LINE_W'(ack), '0);
        op("mid_rd6", 32'h0000_00C0, '0, 1'b0, rd);
        chk("mid_line6", rd, pat(8'h60));
        op("mid_rd5", 32'h0000_00A0, '0, 1'b0, rd);
        chk("mid_line5", rd, pat(8'h50));

        // Async reset during BUSY of a write to index 7.
        op("pre7", 32'h0000_00E0, pat(8'h70), 1'b1, rd);
        addr = 32'h0000_00E0; wdata = pat(8'h80); wr = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("busyrst_ack", LINE_W'(ack), '0);
        chk("busyrst_data", rdata, '0);
        en = 1'b0;
        n = 0;
        repeat (LATENCY + 2) begin
            @(posedge clk); #1;
            if (ack === 1'b1) n++;
        end
        chk("busyrst_noack", LINE_W'(n), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op("rd7", 32'h0000_00E0, '0, 1'b0, rd);
        chk("rd7_data", rd, pat(8'h70));

        // Upper address bits: aliasing or bounds check.
        op("pre0", 32'h0000_0000, pat(8'h01), 1'b1, rd);
        op("wr_hi", 32'h0001_0000, pat(8'hC0), 1'b1, rd);
`ifdef DMEM_BOUNDS_CHECK_EN
        op("rd_hi", 32'h0001_0000, '0, 1'b0, rd);
        chk("rd_hi_zero", rd, '0);
        op("rd0", 32'h0000_0000, '0, 1'b0, rd);
        chk("rd0_kept", rd, pat(8'h01));
`else
        op("rd0", 32'h0000_0000, '0, 1'b0, rd);
        chk("rd0_alias", rd, pat(8'hC0));
        op("rd_hi", 32'h0001_0000, '0, 1'b0, rd);
        chk("rd_hi_alias", rd, pat(8'hC0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_line_responder

// File: doc/dmem_line_responder.md
Name: dmem_line_responder

Overview:
- Line-granular data memory. It is the responder end of the cache-to-memory interface, answering the data cache controller's enable/write/address/256-bit-data requests with a one-cycle ack after a fixed latency.
- Sits below the data cache in the project testbench/top.
- Holds one request at a time and models main-memory access latency with a down-counter.

Parameters:
- ADDR_W, 32: byte address width.
- LINE_W, 256: line width in bits (32 bytes).
- DEPTH, 512: number of lines (16 KB total). Must be a power of two.
- LATENCY, 10: clock edges from request acceptance to ack. Range 1..255.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- addr_i  in  ADDR_W  byte address of line; bits [4:0] ignored.
- data_i  in  LINE_W  write line data.
- enable_i  in  1  request valid; level, held by initiator until ack.
- write_i  in  1  1 = write line, 0 = read line; qualified by enable_i.
- data_o  out  LINE_W  read line data, valid in ack cycle.
- ack_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, ack_o=0, data_o=0, counter=0.
  - Captured request registers cleared.
  - Array contents are not reset.
- Address mapping:
  - IDX_W = log2(DEPTH).
  - index = addr_i[5+IDX_W-1:5].
  - Bits above the index are ignored, so addresses alias, unless the optional feature is enabled.
- States:
  - IDLE: if enable_i=1 at a rising edge, capture index, write_i and data_i; load counter=LATENCY-1; go to BUSY. Otherwise stay in IDLE.
  - BUSY: decrement counter each edge. When counter==0, go to ACK on that edge. With LATENCY=1, IDLE goes straight to ACK.
  - ACK: ack_o=1 for exactly this cycle. Next edge goes to IDLE unconditionally, with ack_o=0.
- Latency:
  - Acceptance edge at cycle T; ack_o is high during cycle T+LATENCY.
  - Next request can be accepted at the edge ending cycle T+LATENCY+1, which is the first IDLE cycle.
- Read:
  - data_o is registered with array[captured index] on the edge entering ACK.
  - data_o holds that value until the next read completes. It is not cleared after ack.
- Write:
  - array[captured index] <= captured data on the edge entering ACK.
  - data_o is unchanged by writes.
- Handshake rules:
  - The request is committed at acceptance. Later changes to addr_i, data_i or write_i are ignored.
  - Dropping enable_i mid-request does not abort. Ack is still issued and the write is still performed.
  - enable_i still high in the IDLE cycle after ack (writeback followed by refill) is a new request, sampled with the current write_i and addr_i.
  - The captured request wins; no request is buffered while BUSY.
- Reset mid-operation: the request is abandoned, no array write, no ack.
- Read/write at the same index back-to-back: the second request sees the first's result.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - Any nonzero addr_i bits above the index field at acceptance mark the request out-of-range.
  - Out-of-range writes are suppressed and reads return all-zero data_o.
  - Ack timing is unchanged.
  - In simulation, $display reports the address.
- Undefined: upper bits are ignored and aliasing occurs. No checking logic.

Decomposition:
- Package dmem_pkg:
  - LINE_W, OFFSET_W=5 and state encoding (IDLE=2'd0, BUSY=2'd1, ACK=2'd2).
  - Shared with the cache's address-split constants.
- Sub-module dmem_line_array:
  - DEPTH x LINE_W storage.
  - Synchronous write enable, registered read port.
  - Instantiated once.
- Top holds the FSM, counter and capture registers.

Test Plan:
- Reset then read: LATENCY=10, read addr 0x0000_0040. Ack is high exactly 10 cycles after acceptance, for one cycle, with data_o = preloaded line 2.
- Write then read: write 0xA5 repeated across the line to 0x0000_0400, then read 0x0000_0400 (index 32). data_o matches the written line; the intervening ack is a single pulse.
- Writeback then refill, as the cache controller issues it: enable_i held high. Write 0x0000_1000 acks, write_i drops, read 0x0000_2000 is accepted in the following IDLE cycle, and the second ack arrives LATENCY+1 cycles after the first.
- Mid-request change: after acceptance of a read at index 5, change addr_i to index 6 and drop enable_i. Ack still fires with the line-5 data.
- Async reset during BUSY of a write at index 7: ack_o=0 immediately, line 7 unchanged, IDLE after release.
- DMEM_BOUNDS_CHECK_EN defined, DEPTH=512: write to 0x0001_0000 is not stored. Reading 0x0001_0000 gives zero; reading 0x0000_0000 keeps its old data.
